// File: rtl/instr_register_pipe_pkg.sv
// Shared definitions for the instruction register pipe: opcode set,
// operand/result widths, stored word layout and the ALU function.
package instr_register_pkg;

    localparam int OP_WIDTH  = 32;
    localparam int RES_WIDTH = 64;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [OP_WIDTH-1:0]  operand_t;
    typedef logic signed [RES_WIDTH-1:0] result_t;

    // One stored entry; field order matches the word read back by the consumer.
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rezultat;
        logic     div0;
    } instr_word_t;

    typedef struct packed {
        result_t rezultat;
        logic    div0;
    } alu_out_t;

    // Result of one instruction. Operands are sign-extended to the result
    // width first, so MULT keeps the full product and DIV/MOD follow the
    // truncate-toward-zero / sign-of-dividend rules of signed arithmetic.
    function automatic alu_out_t alu_calc(input opcode_t opc, input operand_t a, input operand_t b);
        result_t  a_ext;
        result_t  b_ext;
        alu_out_t r;
        a_ext = result_t'({{(RES_WIDTH-OP_WIDTH){a[OP_WIDTH-1]}}, a});
        b_ext = result_t'({{(RES_WIDTH-OP_WIDTH){b[OP_WIDTH-1]}}, b});
        r     = '0;
        case (opc)
            ZERO:  r.rezultat = '0;
            PASSA: r.rezultat = a_ext;
            PASSB: r.rezultat = b_ext;
            ADD:   r.rezultat = a_ext + b_ext;
            SUB:   r.rezultat = a_ext - b_ext;
            MULT:  r.rezultat = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) r.div0 = 1'b1;
                else             r.rezultat = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) r.div0 = 1'b1;
                else             r.rezultat = a_ext % b_ext;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_register_pipe_if.sv
// Write/read handshake bundle between the stimulus side (master) and the
// instruction register (slave).
interface instr_register_pipe_if
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_valid;
    logic              wr_ready;
    opcode_t           opcode;
    operand_t          operand_a;
    operand_t          operand_b;
    logic [AW-1:0]     write_pointer;
    logic              rd_req;
    logic              rd_ready;
    logic [AW-1:0]     read_pointer;
    logic              rd_valid;
    instr_word_t       instruction_word;
    logic              rd_err;
    logic [AW:0]       count;
    logic              full;
    logic              empty;

    modport master (
        output wr_valid, opcode, operand_a, operand_b, write_pointer,
        output rd_req, read_pointer,
        input  wr_ready, rd_ready, rd_valid, instruction_word, rd_err,
        input  count, full, empty
    );

    modport slave (
        input  wr_valid, opcode, operand_a, operand_b, write_pointer,
        input  rd_req, read_pointer,
        output wr_ready, rd_ready, rd_valid, instruction_word, rd_err,
        output count, full, empty
    );

endinterface

// File: rtl/instr_register_pipe_alu.sv
// Combinational ALU used by the write stage; a thin wrapper so the
// arithmetic lives in one shared function.
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc,
    input  operand_t a,
    input  operand_t b,
    output result_t  rezultat,
    output logic     div0
);

    assign {rezultat, div0} = alu_calc(opc, a, b);

endmodule

// File: rtl/instr_register_pipe.sv
// DEPTH-entry instruction register with a registered ALU write stage,
// addressed or FIFO access, valid/ready handshakes and occupancy flags.
module instr_register_pipe
    import instr_register_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int OP_W      = OP_WIDTH,
    parameter int RES_W     = RES_WIDTH,
    parameter bit FIFO_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_register_pipe_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Write stage: one accepted instruction waiting to be committed.
    logic                    stage_valid;
    logic [AW-1:0]           stage_addr;
    opcode_t                 stage_opc;
    logic signed [OP_W-1:0]  stage_a;
    logic signed [OP_W-1:0]  stage_b;
    logic signed [RES_W-1:0] alu_res;
    logic                    alu_div0;
    instr_word_t             commit_word;

    // Storage and bookkeeping.
    instr_word_t             mem [DEPTH];
    logic [DEPTH-1:0]        entry_valid;
    logic [DEPTH-1:0]        entry_valid_nxt;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count_q;

    // Read output registers.
    logic                    rd_valid_q;
    logic                    rd_err_q;
    instr_word_t             rd_word_q;

    // Handshake decode.
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    rd_pop;
    logic                    commit_new;
    logic                    staged_full;
    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_addr;

    instr_alu u_alu (
        .opc      (stage_opc),
        .a        (stage_a),
        .b        (stage_b),
        .rezultat (alu_res),
        .div0     (alu_div0)
    );

    // Address selection, ready generation and the next entry-valid vector.
    always_comb begin
        // NOTE: every variable gets a value before any condition, so no path leaves one unassigned (no latch).
        wr_addr         = FIFO_MODE ? wr_ptr : bus.write_pointer;
        rd_addr         = FIFO_MODE ? rd_ptr : bus.read_pointer;
        staged_full     = ({1'b0, count_q} + (CW+1)'(stage_valid)) >= (CW+1)'(DEPTH);

        bus.wr_ready    = FIFO_MODE ? !staged_full : 1'b1;
        // FIFO reads see only committed entries; addressed reads stall on a pending write to the same address.
        bus.rd_ready    = FIFO_MODE ? (count_q != '0)
                                    : !(stage_valid && (stage_addr == bus.read_pointer));

        wr_acc          = bus.wr_valid && bus.wr_ready;
        rd_acc          = bus.rd_req && bus.rd_ready;
        rd_pop          = FIFO_MODE && rd_acc;
        commit_new      = stage_valid && !entry_valid[stage_addr];

        entry_valid_nxt = entry_valid;
        if (rd_pop)      entry_valid_nxt[rd_addr]    = 1'b0;
        if (stage_valid) entry_valid_nxt[stage_addr] = 1'b1;

        commit_word          = '0;
        commit_word.opc      = stage_opc;
        commit_word.op_a     = stage_a;
        commit_word.op_b     = stage_b;
        commit_word.rezultat = alu_res;
        commit_word.div0     = alu_div0;
    end

    // Capture an accepted write into the ALU stage; advance the FIFO write pointer.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_opc   <= ZERO;
            stage_a     <= '0;
            stage_b     <= '0;
            wr_ptr      <= '0;
        end else begin
            stage_valid <= wr_acc;
            if (wr_acc) begin
                stage_addr <= wr_addr;
                stage_opc  <= bus.opcode;
                stage_a    <= bus.operand_a;
                stage_b    <= bus.operand_b;
                if (FIFO_MODE) wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // Commit the staged word into the array.
    // NOTE: the array is not reset; entry_valid alone decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (stage_valid) mem[stage_addr] <= commit_word;
    end

    // Entry-valid bits and occupancy count, net of a same-edge commit and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_valid <= '0;
            count_q     <= '0;
        end else begin
            entry_valid <= entry_valid_nxt;
            count_q     <= count_q + CW'(commit_new) - CW'(rd_pop);
        end
    end

    // Read port: one-cycle latency, old contents on a same-edge commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_word_q  <= '0;
            rd_ptr     <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            rd_err_q   <= rd_acc && !entry_valid[rd_addr];
            if (rd_acc) begin
                rd_word_q <= entry_valid[rd_addr] ? mem[rd_addr] : '0;
                if (FIFO_MODE) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign bus.rd_valid         = rd_valid_q;
    assign bus.rd_err           = rd_err_q;
    assign bus.instruction_word = rd_word_q;
    assign bus.count            = count_q;
    assign bus.full             = (count_q == CW'(DEPTH));
    assign bus.empty            = (count_q == '0);

endmodule
